// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: direction/mode tags and single-bit step functions
// for Fibonacci and Galois forms. Vectors are carried at LFSR_MAX_W and masked to the live width.
package lfsr_pkg;

  localparam int LFSR_MAX_W = 64;

  localparam logic [23:0] LFSR_DIR_MSB  = "MSB";
  localparam logic [23:0] LFSR_DIR_LSB  = "LSB";
  localparam logic [23:0] LFSR_MODE_FIB = "FIB";
  localparam logic [23:0] LFSR_MODE_GAL = "GAL";

  typedef logic [LFSR_MAX_W-1:0] lfsr_vec_t;

  typedef struct packed {
    lfsr_vec_t state;
    logic      out_bit;
  } lfsr_step_t;

  function automatic lfsr_vec_t lfsr_mask(input int unsigned w);
    return (w >= LFSR_MAX_W) ? '1 : ((lfsr_vec_t'(1) << w) - lfsr_vec_t'(1));
  endfunction

  // Fibonacci: feedback is the parity of the tapped bits, entering at the far end.
  function automatic lfsr_step_t lfsr_step_fib(input lfsr_vec_t   s,
                                               input lfsr_vec_t   taps,
                                               input int unsigned w,
                                               input logic        msb_dir,
                                               input logic        d);
    lfsr_step_t r;
    lfsr_vec_t  top;
    logic       fb;
    top       = lfsr_vec_t'(1) << (w - 1);
    fb        = (^(s & taps)) ^ d;
    r.out_bit = msb_dir ? |(s & top) : s[0];
    if (msb_dir) r.state = ((s << 1) | lfsr_vec_t'(fb)) & lfsr_mask(w);
    else         r.state = (s >> 1) | (fb ? top : '0);
    return r;
  endfunction

  // Galois: the leaving bit (plus din) re-enters and XORs the taps, excluding the entry position.
  function automatic lfsr_step_t lfsr_step_gal(input lfsr_vec_t   s,
                                               input lfsr_vec_t   taps,
                                               input int unsigned w,
                                               input logic        msb_dir,
                                               input logic        d);
    lfsr_step_t r;
    lfsr_vec_t  top;
    lfsr_vec_t  mask;
    logic       f;
    top       = lfsr_vec_t'(1) << (w - 1);
    mask      = lfsr_mask(w);
    r.out_bit = msb_dir ? |(s & top) : s[0];
    f         = r.out_bit ^ d;
    if (msb_dir)
      r.state = (((s << 1) | lfsr_vec_t'(f)) & mask)
                ^ (f ? (taps & mask & ~lfsr_vec_t'(1)) : '0);
    else
      r.state = ((s >> 1) | (f ? top : '0))
                ^ (f ? (taps & mask & ~top) : '0);
    return r;
  endfunction

endpackage

// File: rtl/lfsr_par.sv
// Multi-bit LFSR producing STEP bits per transfer on a valid/ready stream,
// with a one-word output buffer, seed load and all-zero lockup detect/recovery.
module lfsr_par
  import lfsr_pkg::*;
#(
  parameter int             WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS       = 16'hB400,
  parameter int             STEP         = 8,
  parameter logic [23:0]    DIR          = LFSR_DIR_MSB,
  parameter logic [23:0]    MODE         = LFSR_MODE_FIB,
  parameter logic [WIDTH-1:0] SEED       = WIDTH'(1),
  parameter bit             AUTO_RECOVER = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [STEP-1:0]  din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [STEP-1:0]  out_data,
  output logic [WIDTH-1:0] lfsr_state,
  output logic             lockup
);

  localparam logic      MSB_DIR  = (DIR == LFSR_DIR_MSB);
  localparam logic      GAL_MODE = (MODE == LFSR_MODE_GAL);
  localparam lfsr_vec_t TAPS_V   = lfsr_vec_t'(TAPS);

  if (WIDTH < 2 || WIDTH > LFSR_MAX_W) begin : g_err_width
    $error("lfsr_par: WIDTH out of range");
  end
  if (STEP < 1 || STEP > WIDTH) begin : g_err_step
    $error("lfsr_par: STEP must be 1..WIDTH");
  end
  if (SEED == '0) begin : g_err_seed
    $error("lfsr_par: SEED must be non-zero");
  end
  if (TAPS == '0) begin : g_err_taps
    $error("lfsr_par: TAPS must be non-zero");
  end
  if (DIR != LFSR_DIR_MSB && DIR != LFSR_DIR_LSB) begin : g_err_dir
    $error("lfsr_par: DIR must be MSB or LSB");
  end
  if (MODE != LFSR_MODE_FIB && MODE != LFSR_MODE_GAL) begin : g_err_mode
    $error("lfsr_par: MODE must be FIB or GAL");
  end

  logic [WIDTH-1:0] state_p1;
  logic [STEP-1:0]  data_p1;
  logic             vld_p1;

  logic [WIDTH-1:0] next_p0;
  logic [STEP-1:0]  bits_p0;
  logic             fill_p0;
  logic             recover_p0;

  // Stage p0: STEP chained single steps from the registered state, step 0 first.
  always_comb begin
    lfsr_step_t r;
    lfsr_vec_t  s;
    r       = '0;
    s       = lfsr_vec_t'(state_p1);
    bits_p0 = '0;
    for (int k = 0; k < STEP; k++) begin
      r = GAL_MODE ? lfsr_step_gal(s, TAPS_V, WIDTH, MSB_DIR, din[k])
                   : lfsr_step_fib(s, TAPS_V, WIDTH, MSB_DIR, din[k]);
      bits_p0[MSB_DIR ? (STEP - 1 - k) : k] = r.out_bit;
      s = r.state;
    end
    next_p0 = s[WIDTH-1:0];
  end

  assign lockup     = (state_p1 == '0);
  assign recover_p0 = AUTO_RECOVER && lockup;
  assign fill_p0    = !load && (!vld_p1 || out_ready);

  // Stage p1: state register and one-word output buffer; load and recovery flush the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= SEED;
      data_p1  <= '0;
      vld_p1   <= 1'b0;
    end else if (load) begin
      state_p1 <= seed_in;
      vld_p1   <= 1'b0;
    end else if (recover_p0) begin
      state_p1 <= SEED;
      vld_p1   <= 1'b0;
    end else if (fill_p0) begin
      state_p1 <= next_p0;
      data_p1  <= bits_p0;
      vld_p1   <= 1'b1;
    end
  end

  assign out_valid  = vld_p1;
  assign out_data   = data_p1;
  assign lfsr_state = state_p1;

endmodule

// File: tb/tb_lfsr_par.sv
// Bench for lfsr_par: randomized scoreboards on two configurations plus
// directed sequence, stall, load, lockup and period checks.
module tb_lfsr_par;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int parity(input int v);
    int p = 0;
    for (int i = 0; i < 32; i++) p = p ^ ((v >> i) & 1);
    return p;
  endfunction

  // Reference: STEP single steps written with integer arithmetic.
  function automatic void model_fill(input int w, input int taps, input int step,
                                     input bit msb, input bit gal, input int s_in,
                                     input int din, output int s_out, output int word);
    int s, o, d, f, top, modw;
    s = s_in; word = 0; top = 1 << (w - 1); modw = 1 << w;
    for (int k = 0; k < step; k++) begin
      o = msb ? (s / top) % 2 : s % 2;
      d = (din >> k) & 1;
      if (!gal) begin
        f = parity(s & taps) ^ d;
        s = msb ? (s * 2) % modw + f : s / 2 + f * top;
      end else begin
        f = o ^ d;
        if (msb) begin
          s = (s * 2) % modw + f;
          if (f != 0) s = s ^ (taps & ~1);
        end else begin
          s = s / 2 + f * top;
          if (f != 0) s = s ^ (taps & ~top);
        end
      end
      if (msb) word = word * 2 + o;
      else     word = word + (o << k);
    end
    s_out = s;
  endfunction

  // ---------------- random configurations A and B ----------------
  logic rst_r;
  logic a_load, a_ready, a_valid, a_lock;
  logic [3:0] a_seed, a_din, a_data, a_state;
  logic b_load, b_ready, b_valid, b_lock;
  logic [15:0] b_seed, b_state;
  logic [7:0] b_din, b_data;

  lfsr_par #(.WIDTH(4), .TAPS(4'b1100), .STEP(4), .DIR("MSB"), .MODE("FIB"),
             .SEED(4'b0001), .AUTO_RECOVER(1'b1)) u_a (
    .clk(clk), .rst(rst_r), .load(a_load), .seed_in(a_seed), .din(a_din),
    .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data),
    .lfsr_state(a_state), .lockup(a_lock));

  lfsr_par #(.WIDTH(16), .TAPS(16'hB400), .STEP(8), .DIR("LSB"), .MODE("GAL"),
             .SEED(16'hACE1), .AUTO_RECOVER(1'b0)) u_b (
    .clk(clk), .rst(rst_r), .load(b_load), .seed_in(b_seed), .din(b_din),
    .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data),
    .lfsr_state(b_state), .lockup(b_lock));

  int am_state = 1, bm_state = 'hACE1;
  bit am_valid = 0, bm_valid = 0;
  int aq[$];
  int bq[$];
  bit done_ab = 0;

  task automatic model_a();
    int nx, w;
    if (rst_r) begin am_state = 1; am_valid = 0; aq.delete(); end
    else if (a_load) begin am_state = int'(a_seed); am_valid = 0; aq.delete(); end
    else if (am_state == 0) begin am_state = 1; am_valid = 0; aq.delete(); end
    else if (!am_valid || a_ready) begin
      model_fill(4, 'hC, 4, 1, 0, am_state, int'(a_din), nx, w);
      am_state = nx; am_valid = 1; aq.push_back(w);
    end
  endtask

  task automatic model_b();
    int nx, w;
    if (rst_r) begin bm_state = 'hACE1; bm_valid = 0; bq.delete(); end
    else if (b_load) begin bm_state = int'(b_seed); bm_valid = 0; bq.delete(); end
    else if (!bm_valid || b_ready) begin
      model_fill(16, 'hB400, 8, 0, 1, bm_state, int'(b_din), nx, w);
      bm_state = nx; bm_valid = 1; bq.push_back(w);
    end
  endtask

  initial begin
    rst_r = 1'b1;
    a_load = 0; a_seed = 0; a_din = 0; a_ready = 0;
    b_load = 0; b_seed = 0; b_din = 0; b_ready = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      model_a();
      model_b();
      #1;
      rst_r   = (cyc < 2) || ($urandom_range(0, 199) == 0);
      a_load  = ($urandom_range(0, 15) == 0);
      a_seed  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
      a_din   = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'd0;
      a_ready = ($urandom_range(0, 3) != 0);
      b_load  = ($urandom_range(0, 31) == 0);
      b_seed  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      b_din   = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'd0;
      b_ready = ($urandom_range(0, 3) != 0);
    end
    done_ab = 1;
  end

  always @(negedge clk) begin
    if (!done_ab) begin
      check("a_valid", a_valid, am_valid);
      check("a_state", a_state, am_state);
      check("a_lockup", a_lock, am_state == 0);
      if (a_valid && a_ready && !a_load && !rst_r) begin
        if (aq.size() == 0) check("a_queue_empty", 1, 0);
        else check("a_data", a_data, aq.pop_front());
      end
      check("b_valid", b_valid, bm_valid);
      check("b_state", b_state, bm_state);
      check("b_lockup", b_lock, bm_state == 0);
      if (b_valid && b_ready && !b_load && !rst_r) begin
        if (bq.size() == 0) check("b_queue_empty", 1, 0);
        else check("b_data", b_data, bq.pop_front());
      end
    end
  end

  // ---------------- directed configuration D (STEP=1 FIB, no recovery) ----------------
  logic rst_d;
  logic d_load, d_ready, d_valid, d_lock;
  logic [3:0] d_seed, d_state;
  logic [0:0] d_din, d_data;
  bit done_d = 0;

  lfsr_par #(.WIDTH(4), .TAPS(4'b1100), .STEP(1), .DIR("MSB"), .MODE("FIB"),
             .SEED(4'b0001), .AUTO_RECOVER(1'b0)) u_d (
    .clk(clk), .rst(rst_d), .load(d_load), .seed_in(d_seed), .din(d_din),
    .out_valid(d_valid), .out_ready(d_ready), .out_data(d_data),
    .lfsr_state(d_state), .lockup(d_lock));

  initial begin
    int ms, nx, w, per;
    int tbl [4] = '{2, 4, 9, 3};
    rst_d = 1; d_load = 0; d_seed = 0; d_din = 0; d_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("d_rst_state", d_state, 1);
    check("d_rst_valid", d_valid, 0);
    check("d_rst_data", d_data, 0);
    check("d_rst_lockup", d_lock, 0);
    rst_d = 0;
    ms = 1; per = 0; w = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      model_fill(4, 'hC, 1, 1, 0, ms, 0, nx, w);
      ms = nx;
      check("d_seq_state", d_state, ms);
      check("d_seq_data", d_data, w);
      check("d_seq_valid", d_valid, 1);
      if (i < 4) check("d_seq_table", d_state, tbl[i]);
      if (d_state == 4'd1 && per == 0) per = i + 1;
    end
    check("d_period", per, 15);
    // stall: state and word held, din ignored
    d_ready = 0; d_din = 1;
    repeat (5) begin
      @(posedge clk); #1;
      check("d_stall_state", d_state, ms);
      check("d_stall_data", d_data, w);
      check("d_stall_valid", d_valid, 1);
    end
    d_ready = 1; d_din = 0;
    @(posedge clk); #1;
    model_fill(4, 'hC, 1, 1, 0, ms, 0, nx, w); ms = nx;
    check("d_release_state", d_state, ms);
    // load while valid and ready drops the buffered word
    d_load = 1; d_seed = 4'b1000;
    @(posedge clk); #1;
    check("d_load_valid", d_valid, 0);
    check("d_load_state", d_state, 8);
    d_load = 0;
    @(posedge clk); #1;
    model_fill(4, 'hC, 1, 1, 0, 8, 0, nx, w);
    check("d_load_data", d_data, 1);
    check("d_load_next", d_state, nx);
    // din injection on first fill from 0001
    d_load = 1; d_seed = 4'b0001;
    @(posedge clk); #1;
    d_load = 0; d_din = 1;
    @(posedge clk); #1;
    check("d_din_state", d_state, 3);
    d_din = 0;
    // mid-stream reset discards the buffered word
    rst_d = 1;
    @(posedge clk); #1;
    check("d_midrst_valid", d_valid, 0);
    check("d_midrst_state", d_state, 1);
    check("d_midrst_data", d_data, 0);
    rst_d = 0;
    // zero load without recovery: stays locked, streams zeros
    d_load = 1; d_seed = 4'b0000;
    @(posedge clk); #1;
    check("d_zero_lockup", d_lock, 1);
    check("d_zero_valid", d_valid, 0);
    d_load = 0;
    repeat (4) begin
      @(posedge clk); #1;
      check("d_stuck_lockup", d_lock, 1);
      check("d_stuck_valid", d_valid, 1);
      check("d_stuck_data", d_data, 0);
    end
    done_d = 1;
  end

  // ---------------- configuration C (GAL, WIDTH=16, STEP=1) period ----------------
  logic rst_c;
  logic c_load, c_ready, c_valid, c_lock;
  logic [15:0] c_seed, c_state;
  logic [0:0] c_din, c_data;
  bit done_c = 0;

  lfsr_par #(.WIDTH(16), .TAPS(16'hB400), .STEP(1), .DIR("MSB"), .MODE("GAL"),
             .SEED(16'h0001), .AUTO_RECOVER(1'b1)) u_c (
    .clk(clk), .rst(rst_c), .load(c_load), .seed_in(c_seed), .din(c_din),
    .out_valid(c_valid), .out_ready(c_ready), .out_data(c_data),
    .lfsr_state(c_state), .lockup(c_lock));

  initial begin
    int ms, nx, w, mp, dp, mism;
    rst_c = 1; c_load = 0; c_ready = 1; c_din = 0; c_seed = 0;
    ms = 1; mp = 0;
    do begin
      model_fill(16, 'hB400, 1, 1, 1, ms, 0, nx, w);
      ms = nx; mp++;
    end while (ms != 1 && mp < 70000);
    repeat (2) @(posedge clk);
    #1;
    rst_c = 0;
    ms = 1; dp = 0; mism = 0;
    for (int i = 0; i < 70000 && dp == 0; i++) begin
      @(posedge clk); #1;
      model_fill(16, 'hB400, 1, 1, 1, ms, 0, nx, w);
      ms = nx;
      if (c_state !== ms[15:0] || c_data !== w[0:0] || c_valid !== 1'b1) mism++;
      if (c_state == 16'd1) dp = i + 1;
    end
    check("c_gal_mismatches", mism, 0);
    check("c_gal_period", dp, mp);
    done_c = 1;
  end

  // ---------------- completion ----------------
  initial begin
    bit all_done;
    all_done = 0;
    fork
      begin wait (done_ab && done_d && done_c); all_done = 1; end
      #2000000;
    join_any
    check("completion_timeout", all_done, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
